// File: rtl/colour_pkg.sv
// colour_pkg: shared types and constants for the RGB 3:3:2 -> 12-sector HSV
// converter and its sequential divider.
//   state_t  : converter FSM encoding
//   calc_t   : per-pixel operands latched in CALC
//   expand_b : 2-bit blue to 3-bit scale
package colour_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    DIV_S = 3'd2,
    DIV_H = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int HUE_SECTORS = 12;
  localparam int HUE_BASE_R  = 0;
  localparam int HUE_BASE_G  = 4;
  localparam int HUE_BASE_B  = 8;
  localparam int S_SCALE     = 7;
  localparam int DIV_ITER    = 6;
  localparam int LATENCY     = 16;
  localparam int DVD_W       = 6;
  localparam int DVR_W       = 4;

  typedef struct packed {
    logic [2:0] vmax;
    logic [2:0] delta;
    logic [3:0] base;
    logic       neg;
    logic [2:0] diff;
  } calc_t;

  // Replicate the blue MSB so 3 maps to full scale 7.
  function automatic logic [2:0] expand_b(input logic [1:0] bb);
    return {bb, bb[1]};
  endfunction

endpackage

// File: rtl/div_seq.sv
// div_seq: 6/4-bit restoring divider, one quotient bit per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load operands (ignored while busy)
//   dividend  : 6-bit unsigned numerator
//   divisor   : 4-bit unsigned denominator, never 0
//   busy      : iterations in progress
//   done      : high in the cycle whose edge retires the last iteration
//   quotient  : result, valid from the edge after done until the next start
module div_seq
  import colour_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVR_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  logic [DVR_W-1:0] rem;
  logic [DVD_W-1:0] dvd;
  logic [DVR_W-1:0] dvr;
  logic [2:0]       cnt;
  logic [DVR_W:0]   trial;

  // Partial remainder stays below the divisor, so one extra bit covers the shift.
  assign trial = {rem, dvd[DVD_W-1]};
  assign done  = busy && (cnt == 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvr      <= '0;
      quotient <= '0;
    end else if (start && !busy) begin
      busy     <= 1'b1;
      cnt      <= 3'(DIV_ITER);
      rem      <= '0;
      dvd      <= dividend;
      dvr      <= divisor;
      quotient <= '0;
    end else if (busy) begin
      dvd <= {dvd[DVD_W-2:0], 1'b0};
      if (trial >= {1'b0, dvr}) begin
        rem      <= DVR_W'(trial - {1'b0, dvr});
        quotient <= {quotient[DVD_W-2:0], 1'b1};
      end else begin
        rem      <= DVR_W'(trial);
        quotient <= {quotient[DVD_W-2:0], 1'b0};
      end
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rgb_to_hsv.sv
// rgb_to_hsv: packed RGB 3:3:2 pixel -> HSV (h 0-11, s 0-7, v 0-7).
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready, r/g/b    : pixel input handshake
//   out_valid/out_ready, h/s/v  : result output handshake
// Parameter HOLD_LAST: 1 keeps h/s/v after the output handshake, 0 clears them.
// Macro RGB_TO_HSV_FAST_GRAY_EN: gray pixels (delta 0) skip both divisions.
// Fixed flow IDLE -> CALC -> DIV_S -> DIV_H -> DONE; the first DONE cycle
// commits the result, so out_valid rises 16 edges after accept.
module rgb_to_hsv
  import colour_pkg::*;
#(
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] r,
  input  logic [2:0] g,
  input  logic [1:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] h,
  output logic [2:0] s,
  output logic [2:0] v
);

  state_t           state, state_nxt;
  logic [2:0]       pix_r, pix_g, pix_b3;
  calc_t            calc;
  logic [2:0]       s_q;
  logic [2:0]       mx, mn, hx, hy;
  logic [3:0]       base;
  logic             accept;
  logic             div_start, div_busy, div_done;
  logic [DVD_W-1:0] div_dividend, div_quot;
  logic [DVR_W-1:0] div_divisor;
  logic [1:0]       hq;
  logic [3:0]       hue_up, hue_dn, hue;

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = CALC;
      CALC: begin
`ifdef RGB_TO_HSV_FAST_GRAY_EN
        state_nxt = (mx == mn) ? DONE : DIV_S;
`else
        state_nxt = DIV_S;
`endif
      end
      DIV_S: if (div_done) state_nxt = DIV_H;
      DIV_H: if (div_done) state_nxt = DONE;
      DONE:  if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; the divider is launched on the first cycle of each DIV state.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    div_start = ((state == DIV_S) || (state == DIV_H)) && !div_busy && !rst;
  end

  // Max channel with r > g > b priority on ties, and its hue operand pair.
  always_comb begin
    if (pix_r >= pix_g && pix_r >= pix_b3) begin
      mx = pix_r;  base = 4'(HUE_BASE_R); hx = pix_g;  hy = pix_b3;
    end else if (pix_g >= pix_b3) begin
      mx = pix_g;  base = 4'(HUE_BASE_G); hx = pix_b3; hy = pix_r;
    end else begin
      mx = pix_b3; base = 4'(HUE_BASE_B); hx = pix_r;  hy = pix_g;
    end
    mn = pix_r;
    if (pix_g  < mn) mn = pix_g;
    if (pix_b3 < mn) mn = pix_b3;
  end

  // Divider operands. Zero divisors are replaced by 1; those results are
  // overridden at commit time anyway.
  always_comb begin
    if (state == DIV_H) begin
      div_dividend = {1'b0, calc.diff, 2'b00} + 6'(calc.delta);
      div_divisor  = (calc.delta == 3'd0) ? 4'd1 : {calc.delta, 1'b0};
    end else begin
      div_dividend = 6'(calc.delta) * 6'(S_SCALE);
      div_divisor  = (calc.vmax == 3'd0) ? 4'd1 : {1'b0, calc.vmax};
    end
  end

  // Hue step q is at most 2; base-q wraps through 12 only from the red base.
  always_comb begin
    hq     = (div_quot > 6'd2) ? 2'd2 : div_quot[1:0];
    hue_up = calc.base + {2'b00, hq};
    if (hue_up >= 4'(HUE_SECTORS)) hue_up = hue_up - 4'(HUE_SECTORS);
    if ({2'b00, hq} > calc.base) hue_dn = calc.base + 4'(HUE_SECTORS) - {2'b00, hq};
    else                         hue_dn = calc.base - {2'b00, hq};
    hue = calc.neg ? hue_dn : hue_up;
  end

  div_seq u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b3    <= '0;
      calc      <= '0;
      s_q       <= '0;
      out_valid <= 1'b0;
      h         <= '0;
      s         <= '0;
      v         <= '0;
    end else begin
      if (accept) begin
        pix_r  <= r;
        pix_g  <= g;
        pix_b3 <= expand_b(b);
      end
      if (state == CALC)
        calc <= '{vmax:  mx,
                  delta: mx - mn,
                  base:  base,
                  neg:   (hx < hy),
                  diff:  (hx < hy) ? (hy - hx) : (hx - hy)};
      // Saturation quotient is ready when DIV_H relaunches the divider.
      if ((state == DIV_H) && div_start)
        s_q <= (div_quot > 6'd7) ? 3'd7 : div_quot[2:0];
      if (state == DONE) begin
        if (!out_valid) begin
          // delta==0 covers max==0 too; also guards stale values on the gray bypass.
          out_valid <= 1'b1;
          v         <= calc.vmax;
          s         <= (calc.delta == 3'd0) ? 3'd0 : s_q;
          h         <= (calc.delta == 3'd0) ? 4'd0 : hue;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          if (!HOLD_LAST) begin
            h <= '0;
            s <= '0;
            v <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv.sv
// tb_rgb_to_hsv: directed + random check of rgb_to_hsv. Two instances share
// stimulus: u_hold (HOLD_LAST=1) and u_clr (HOLD_LAST=0).
module tb_rgb_to_hsv;
  import colour_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] r = '0, g = '0;
  logic [1:0] b = '0;
  logic       in_ready_a, out_valid_a, in_ready_c, out_valid_c;
  logic [3:0] h_a, h_c;
  logic [2:0] s_a, v_a, s_c, v_c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  rgb_to_hsv #(.HOLD_LAST(1'b1)) u_hold (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .r(r), .g(g), .b(b), .out_valid(out_valid_a), .out_ready(out_ready),
    .h(h_a), .s(s_a), .v(v_a));

  rgb_to_hsv #(.HOLD_LAST(1'b0)) u_clr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .r(r), .g(g), .b(b), .out_valid(out_valid_c), .out_ready(out_ready),
    .h(h_c), .s(s_c), .v(v_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: HSV from the arithmetic definition (b scaled by 7/3, rounded).
  function automatic void model(input int pr, input int pg, input int pb,
                                output int eh, output int es, output int ev);
    int b3, mx, mn, dl, bs, x, y, q, hh;
    b3 = (pb * 7 + 1) / 3;
    if (pr >= pg && pr >= b3) begin mx = pr; bs = 0; x = pg; y = b3; end
    else if (pg >= b3)        begin mx = pg; bs = 4; x = b3; y = pr; end
    else                      begin mx = b3; bs = 8; x = pr; y = pg; end
    mn = pr;
    if (pg < mn) mn = pg;
    if (b3 < mn) mn = b3;
    dl = mx - mn;
    ev = mx;
    es = (mx == 0) ? 0 : (7 * dl) / mx;
    if (dl == 0) eh = 0;
    else begin
      q  = (4 * ((x > y) ? x - y : y - x) + dl) / (2 * dl);
      hh = (x >= y) ? bs + q : bs - q;
      eh = (hh + 12) % 12;
    end
  endfunction

  // s==0 exactly when the pixel is gray.
  function automatic int exp_lat(input int es);
`ifdef RGB_TO_HSV_FAST_GRAY_EN
    return (es == 0) ? 2 : LATENCY;
`else
    return (es == 0) ? LATENCY : LATENCY;
`endif
  endfunction

  task automatic pixel(input int pr, input int pg, input int pb, input int hold,
                       input bit keep_valid);
    int eh, es, ev, lat, wait_n, bad;
    logic [9:0] exp10;
    model(pr, pg, pb, eh, es, ev);
    exp10 = {4'(eh), 3'(es), 3'(ev)};
    wait_n = 0;
    while (!in_ready_a && wait_n < 50) begin step(); wait_n++; end
    chk("in_ready_idle", {in_ready_a, in_ready_c}, 2'b11);
    in_valid = 1'b1; r = 3'(pr); g = 3'(pg); b = 2'(pb);
    step();
    in_valid = keep_valid; r = 3'($urandom); g = 3'($urandom); b = 2'($urandom);
    lat = 0; bad = 0;
    while (!out_valid_a && lat < 40) begin
      if (in_ready_a || in_ready_c || out_valid_c) bad++;
      step();
      lat++;
    end
    chk("latency", lat, exp_lat(es));
    chk("busy_no_ready", bad, 0);
    chk("hsv_hold_inst", {h_a, s_a, v_a}, exp10);
    chk("hsv_clr_inst", {out_valid_c, h_c, s_c, v_c}, {1'b1, exp10});
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (!keep_valid) in_valid = 1'($urandom);
      r = 3'($urandom); g = 3'($urandom); b = 2'($urandom);
      step();
      if (!out_valid_a || !out_valid_c || in_ready_a || in_ready_c ||
          {h_a, s_a, v_a} != exp10 || {h_c, s_c, v_c} != exp10) bad++;
    end
    chk("backpressure_stable", bad, 0);
    in_valid = keep_valid;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_drops", {out_valid_a, out_valid_c}, 2'b00);
    chk("hold_last_keeps", {h_a, s_a, v_a}, exp10);
    chk("clear_on_handshake", {h_c, s_c, v_c}, 10'd0);
    chk("ready_after_handshake", {in_ready_a, in_ready_c}, 2'b11);
  endtask

  initial begin
    int bad;
    // Reset state
    rst = 1'b1;
    step(); step();
    chk("reset_ready_low", {in_ready_a, in_ready_c}, 2'b00);
    chk("reset_valid", {out_valid_a, out_valid_c}, 2'b00);
    chk("reset_hsv", {h_a, s_a, v_a, h_c, s_c, v_c}, 20'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {in_ready_a, in_ready_c}, 2'b11);

    // Directed pixels
    pixel(7, 3, 0, 0, 1'b0);   // h1 s7 v7
    pixel(0, 7, 3, 0, 1'b0);   // g/b tie -> h6
    pixel(7, 0, 1, 0, 1'b0);   // negative wrap -> h11
    pixel(5, 5, 2, 0, 1'b0);   // gray
    pixel(0, 0, 0, 0, 1'b0);   // black
    pixel(6, 3, 0, 5, 1'b0);   // backpressure with ignored in_valid pulses

    // Reset during DIV_S aborts the pixel
    in_valid = 1'b1; r = 3'd7; g = 3'd3; b = 2'd0;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("abort_valid", {out_valid_a, out_valid_c}, 2'b00);
    chk("abort_hsv", {h_a, s_a, v_a, h_c, s_c, v_c}, 20'd0);
    chk("abort_ready", {in_ready_a, in_ready_c}, 2'b11);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid_a || out_valid_c) bad++;
    end
    chk("abort_no_output", bad, 0);
    pixel(7, 0, 0, 0, 1'b0);

    // Random pixels with random backpressure
    for (int i = 0; i < 40; i++)
      pixel(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 6; i++)
      pixel(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 0, 1'b1);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
